// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the single-bit-cell memory controller.
package mem_ctrl_pkg;

  localparam int ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    HOLD,
    READ,
    RESP
  } state_t;

endpackage

// File: rtl/mem_ctrl.sv
// Request/response controller sequencing one access at a time onto a 1-bit
// wide memory: SETUP, WE pulse (WRITE+HOLD) or RE pulse (READ), then RESP.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_rdata,
  output logic [ADDR_W-1:0] mem_sel,
  output logic              mem_we,
  output logic              mem_re,
  output logic              mem_dout,
  output logic              mem_oe,
  input  logic              mem_din
);

  localparam int              CW      = $clog2(WE_CYCLES + 1);
  localparam logic [CW-1:0]   WE_LAST = CW'(WE_CYCLES - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic              wdata_q;
  logic              rdata_q;
  logic [CW-1:0]     we_cnt;
  logic              accept;

  // rst_n gates ready so it drops the instant reset asserts, yet is already
  // high in the first cycle after release.
  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = wr_q ? WRITE : READ;
      WRITE:   if (we_cnt == WE_LAST) state_nxt = HOLD;
      HOLD:    state_nxt = RESP;
      READ:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 1'b0;
      rdata_q <= 1'b0;
      we_cnt  <= '0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wr_q    <= req_write;
        wdata_q <= req_wdata;
        rdata_q <= 1'b0;
      end
      if (state == SETUP) we_cnt <= '0;
      if (state == WRITE) we_cnt <= we_cnt + 1'b1;
      if (state == READ)  rdata_q <= mem_din;
    end
  end

  // Address only moves on the IDLE->SETUP edge, so it is stable under WE/RE.
  assign mem_sel   = addr_q;
  assign mem_we    = (state == WRITE);
  assign mem_re    = (state == READ);
  assign mem_oe    = wr_q && ((state == SETUP) || (state == WRITE) || (state == HOLD));
  assign mem_dout  = mem_oe && wdata_q;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and random checks of mem_ctrl against 16x1 behavioural memories.
module tb_mem_ctrl;

  logic       clk, rst_n;
  logic       req_valid, req_valid3, req_write, req_wdata, rsp_ready;
  logic [3:0] req_addr;
  logic       req_ready, rsp_valid, rsp_rdata, mem_we, mem_re, mem_dout, mem_oe, mem_din;
  logic [3:0] mem_sel;
  logic       req_ready3, rsp_valid3, rsp_rdata3, mem_we3, mem_re3, mem_dout3, mem_oe3, mem_din3;
  logic [3:0] mem_sel3;

  logic [15:0] mem_m, mem3, ref_mem;
  logic [3:0]  sel_prev, sel3_prev;
  int          viol_ex, viol_sel, viol_ex3, viol_sel3;
  int          n_tests, n_fail;

  mem_ctrl #(.ADDR_W(4), .WE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_re(mem_re), .mem_dout(mem_dout),
    .mem_oe(mem_oe), .mem_din(mem_din)
  );

  mem_ctrl #(.ADDR_W(4), .WE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3),
    .mem_sel(mem_sel3), .mem_we(mem_we3), .mem_re(mem_re3), .mem_dout(mem_dout3),
    .mem_oe(mem_oe3), .mem_din(mem_din3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)  mem_m[mem_sel] <= mem_dout;
    if (mem_we3) mem3[mem_sel3] <= mem_dout3;
  end
  assign mem_din  = mem_m[mem_sel];
  assign mem_din3 = mem3[mem_sel3];

  // Protocol monitors: WE/RE exclusive, select frozen while either is high.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_ex <= 0; viol_sel <= 0; viol_ex3 <= 0; viol_sel3 <= 0;
      sel_prev <= '0; sel3_prev <= '0;
    end else begin
      if (mem_we && mem_re)   viol_ex  <= viol_ex + 1;
      if (mem_we3 && mem_re3) viol_ex3 <= viol_ex3 + 1;
      if ((mem_we || mem_re) && mem_sel != sel_prev)     viol_sel  <= viol_sel + 1;
      if ((mem_we3 || mem_re3) && mem_sel3 != sel3_prev) viol_sel3 <= viol_sel3 + 1;
      sel_prev  <= mem_sel;
      sel3_prev <= mem_sel3;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transaction on dut; stall > 0 holds rsp_ready low that many cycles.
  task automatic op(input logic wr, input logic [3:0] a, input logic d, input int stall,
                    output logic rd, output int lat, output logic [3:0] sel, output int wt);
    req_write = wr; req_addr = a; req_wdata = d; req_valid = 1'b1;
    rsp_ready = (stall == 0);
    wt = 0;
    do begin @(negedge clk); wt++; end while (!req_ready && wt < 50);
    chk("req_ready", {31'b0, req_ready}, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0; sel = '0;
    do begin
      @(negedge clk); lat++;
      if (mem_we || mem_re) sel = mem_sel;
    end while (!rsp_valid && lat < 30);
    rd = rsp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, rsp_valid}, 1);
      chk("stall_rdata", {31'b0, rsp_rdata}, {31'b0, rd});
      chk("stall_ready", {31'b0, req_ready}, 0);
      chk("stall_re",    {31'b0, mem_re}, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic       rd, wr, d;
    logic [3:0] sel, a;
    int         lat, wt, nwe, noe, nbad;
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_valid3 = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = 1'b0; rsp_ready = 1'b1; ref_mem = '0;
    mem_m = '0; mem3 = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, req_ready}, 0);
    chk("rst_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rdata", {31'b0, rsp_rdata}, 0);
    chk("rst_ctl",   {28'b0, mem_we, mem_re, mem_oe, mem_dout}, 0);
    chk("rst_sel",   {28'b0, mem_sel}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'b0, req_ready}, 1);
    @(posedge clk); #1;

    // Write 5=1 then read it back, with fixed latencies.
    op(1'b1, 4'd5, 1'b1, 0, rd, lat, sel, wt);
    ref_mem[5] = 1'b1;
    chk("wr_lat", lat, 4); chk("wr_rdata", {31'b0, rd}, 0); chk("wr_sel", {28'b0, sel}, 5);
    op(1'b0, 4'd5, 1'b0, 0, rd, lat, sel, wt);
    chk("rd_lat", lat, 3); chk("rd_data", {31'b0, rd}, 1); chk("rd_sel", {28'b0, sel}, 5);
    chk("b2b_gap", wt, 1);

    // Sweep all cells with pattern addr[0].
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      op(1'b1, a, a[0], 0, rd, lat, sel, wt);
      ref_mem[a] = a[0];
      chk("sweep_wsel", {28'b0, sel}, {28'b0, a});
    end
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      op(1'b0, a, 1'b0, 0, rd, lat, sel, wt);
      chk("sweep_rdata", {31'b0, rd}, {31'b0, a[0]});
      chk("sweep_rsel",  {28'b0, sel}, {28'b0, a});
    end

    // Response stall of 10 cycles on a read of 1.
    op(1'b0, 4'd5, 1'b0, 10, rd, lat, sel, wt);
    chk("stall_data", {31'b0, rd}, 1);

    // Random traffic against the reference memory.
    for (int i = 0; i < 1000; i++) begin
      wr = 1'($urandom_range(0, 1)); a = 4'($urandom_range(0, 15)); d = 1'($urandom_range(0, 1));
      op(wr, a, d, 0, rd, lat, sel, wt);
      chk("rnd_lat", lat, wr ? 4 : 3);
      chk("rnd_gap", wt, 1);
      if (wr) ref_mem[a] = d;
      else    chk("rnd_rdata", {31'b0, rd}, {31'b0, ref_mem[a]});
    end

    // WE_CYCLES=3 write: pulse width and stable sel/dout while driving.
    req_write = 1'b1; req_addr = 4'd9; req_wdata = 1'b1; req_valid3 = 1'b1;
    @(negedge clk);
    chk("w3_ready", {31'b0, req_ready3}, 1);
    @(posedge clk); #1 req_valid3 = 1'b0;
    lat = 0; nwe = 0; noe = 0; nbad = 0;
    do begin
      @(negedge clk); lat++;
      if (mem_we3) nwe++;
      if (mem_oe3) begin
        noe++;
        if (mem_sel3 !== 4'd9 || mem_dout3 !== 1'b1) nbad++;
      end
    end while (!rsp_valid3 && lat < 30);
    chk("w3_lat", lat, 6); chk("w3_we_cycles", nwe, 3);
    chk("w3_oe_cycles", noe, 5); chk("w3_stable", nbad, 0);
    chk("w3_rdata", {31'b0, rsp_rdata3}, 0);
    @(posedge clk); #1;
    req_write = 1'b0; req_valid3 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 req_valid3 = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!rsp_valid3 && lat < 30);
    chk("r3_lat", lat, 3); chk("r3_data", {31'b0, rsp_rdata3}, 1);
    @(posedge clk); #1;

    // Reset asserted in the middle of the WE pulse.
    req_write = 1'b1; req_addr = 4'd3; req_wdata = 1'b1; req_valid3 = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 req_valid3 = 1'b0;
    @(posedge clk); #1;
    chk("mid_we_on", {31'b0, mem_we3}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_we_off", {31'b0, mem_we3}, 0);
    chk("mid_valid",  {31'b0, rsp_valid3}, 0);
    chk("mid_ready",  {31'b0, req_ready3}, 0);
    chk("mid_oe",     {31'b0, mem_oe3}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready3", {31'b0, req_ready3}, 1);
    chk("post_rst_valid3", {31'b0, rsp_valid3}, 0);
    chk("post_rst_ready",  {31'b0, req_ready}, 1);

    chk("we_re_excl",  viol_ex, 0);
    chk("sel_stable",  viol_sel, 0);
    chk("we_re_excl3", viol_ex3, 0);
    chk("sel_stable3", viol_sel3, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
